debug_cmd_decoder: RTL and testbench
====================================

DEBUG_CMD_DECODER -- requirements
Module: debug_cmd_decoder

Interface
REQ-001 SHALL have parameter SIZE, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, instruction-memory byte-address width.
REQ-003 SHALL have parameter MAX_INSTRUCTION, default 64, instruction-memory depth in words.
REQ-004 SHALL have port i_clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_rx_data  in  8  byte from uart_rx.
REQ-007 SHALL have port i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
REQ-008 SHALL have port o_imem_we  out  1  instruction-memory write strobe.
REQ-009 SHALL have port o_imem_addr  out  ADDR_WIDTH  byte address of write.
REQ-010 SHALL have port o_imem_data  out  SIZE  assembled instruction word.
REQ-011 SHALL have port o_cpu_rst  out  1  one-cycle pipeline/PC reset pulse.
REQ-012 SHALL have port o_run  out  1  CPU free-running enable.
REQ-013 SHALL have port o_step  out  1  one-cycle single-step enable.
REQ-014 SHALL have port o_dump_req  out  1  dump request to transmit side, level.
REQ-015 SHALL have port o_dump_sel  out  3  0=regs,1=IF/ID,2=ID/EX,3=EX/MEM,4=MEM/WB.
REQ-016 SHALL have port i_dump_done  in  1  one-cycle strobe, dump fully sent.
REQ-017 SHALL have port o_step_mode  out  1  1=step-by-step, 0=continuous.
REQ-018 SHALL have port o_err  out  2  sticky: bit0 load overflow, bit1 byte dropped.

Function
REQ-019 SHALL implement states IDLE, LOAD, DUMP; commands decoded only in IDLE on i_rx_valid.
REQ-020 SHALL decode: 0x02->LOAD; 0x03..0x07->DUMP with o_dump_sel=cmd-3; 0x08 step_mode=0; 0x09 step_mode=1; 0x0A step; 0x0D start; all others ignored, no state change.
REQ-021 SHALL on 0x02 clear byte index, word count and o_imem_addr to 0.
REQ-022 SHALL in LOAD assemble bytes LSB first: byte k to bits [8k+7:8k], k=0..3.
REQ-023 SHALL on 4th byte assert o_imem_we for exactly the next cycle with full word, then increment o_imem_addr by 4 (latency: 4th i_rx_valid -> o_imem_we one cycle later).
REQ-024 SHALL in LOAD treat 0x0C as end-of-load only at byte index 0 and return to IDLE; 0x0C at index 1..3 is data.
REQ-025 SHALL when word count equals MAX_INSTRUCTION suppress o_imem_we, set o_err[0], keep consuming bytes until end-of-load.
REQ-026 SHALL on 0x0D pulse o_cpu_rst one cycle, set started flag; next cycle o_run=1 if step_mode=0.
REQ-027 SHALL hold o_run=started AND NOT step_mode; 0x09 while running drops o_run next cycle, 0x08 while started raises it.
REQ-028 SHALL on 0x0A pulse o_step exactly one cycle only if started and step_mode=1; otherwise ignore.
REQ-029 SHALL in DUMP hold o_dump_req=1 and o_dump_sel stable until i_dump_done, then deassert next cycle and return to IDLE.
REQ-030 SHALL drop any i_rx_valid byte arriving in DUMP and set o_err[1].
REQ-031 SHALL treat i_dump_done outside DUMP as no-op.
REQ-032 SHALL clear started on 0x02 (reloading halts CPU: o_run=0).

Reset
REQ-033 SHALL on i_rst_n=0, asynchronously: state IDLE, step_mode=0, started=0, byte index/word count/o_imem_addr/o_imem_data=0, all strobes, o_run, o_dump_req, o_dump_sel, o_err=0.
REQ-034 SHALL on reset mid-LOAD discard partial word with no write.

Structure
REQ-035 SHALL place command opcodes, dump-select codes and state encoding in shared package debug_pkg.
REQ-036 SHALL use one sub-module, word_assembler (byte index, shift register, word-ready strobe).

Verification
REQ-037 SHALL verify: 0x02, bytes 03 00 01 3C, 0x0C -> one o_imem_we, addr 0, data 0x3C010003, state IDLE.
REQ-038 SHALL verify: 0x02, 65 words -> 64 writes, addrs 0..252, o_err[0]=1, no 65th write.
REQ-039 SHALL verify: 0x09, 0x0D, 0x0A x3 -> one o_cpu_rst, o_run=0, three single-cycle o_step pulses.
REQ-040 SHALL verify: 0x05 then byte 0x0A before i_dump_done -> o_dump_sel=2 held, o_step never pulses, o_err[1]=1.
REQ-041 SHALL verify: 0x08, 0x0D -> o_run=1; 0x09 -> o_run=0 next cycle; 0x0A -> one o_step.
REQ-042 SHALL verify: i_rst_n low after 2 load bytes -> no write, all outputs 0; fresh 0x02 load writes addr 0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared encodings for the UART debug command decoder: command opcodes,
// dump-select codes and FSM state encoding.
package debug_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DUMP = 2'd2
   } state_t;

   localparam logic [7:0] CMD_LOAD       = 8'h02;
   localparam logic [7:0] CMD_DUMP_REGS  = 8'h03;
   localparam logic [7:0] CMD_DUMP_MEMWB = 8'h07;
   localparam logic [7:0] CMD_CONT       = 8'h08;
   localparam logic [7:0] CMD_STEP_MODE  = 8'h09;
   localparam logic [7:0] CMD_STEP       = 8'h0A;
   localparam logic [7:0] CMD_EOL        = 8'h0C;
   localparam logic [7:0] CMD_START      = 8'h0D;

   localparam logic [2:0] DSEL_REGS  = 3'd0;
   localparam logic [2:0] DSEL_IFID  = 3'd1;
   localparam logic [2:0] DSEL_IDEX  = 3'd2;
   localparam logic [2:0] DSEL_EXMEM = 3'd3;
   localparam logic [2:0] DSEL_MEMWB = 3'd4;

   function automatic logic [2:0] dump_sel_of(input logic [7:0] cmd);
      return 3'(cmd - CMD_DUMP_REGS);
   endfunction

endpackage

// File: rtl/debug_cmd_decoder_word_assembler.sv
// Collects UART bytes LSB-first into an instruction word; word_ready pulses
// for the cycle after the last byte of a word lands.
module word_assembler #(
   parameter int SIZE = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            clr,
   input  logic            byte_valid,
   input  logic [7:0]      byte_data,
   output logic [SIZE-1:0] word,
   output logic            word_ready,
   output logic            empty
);

   localparam int BYTES = SIZE / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [IDX_W-1:0] byte_idx;

   // Right-shifting in at the top leaves the first byte at [7:0] once full.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         byte_idx   <= '0;
         word       <= '0;
         word_ready <= 1'b0;
      end else begin
         word_ready <= 1'b0;
         if (clr) begin
            byte_idx <= '0;
         end else if (byte_valid) begin
            word <= {byte_data, word[SIZE-1:8]};
            if (byte_idx == IDX_W'(BYTES - 1)) begin
               byte_idx   <= '0;
               word_ready <= 1'b1;
            end else begin
               byte_idx <= byte_idx + 1'b1;
            end
         end
      end
   end

   assign empty = (byte_idx == '0);

endmodule

// File: rtl/debug_cmd_decoder.sv
// UART debug command decoder: loads instruction memory, controls CPU
// run/step and requests pipeline dumps from the transmit side.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for a command byte
//   ST_LOAD | assembling instruction words until 0x0C at a word boundary
//   ST_DUMP | dump requested, waiting for i_dump_done; rx bytes dropped
module debug_cmd_decoder
   import debug_pkg::*;
#(
   parameter int SIZE            = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_INSTRUCTION = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_imem_we,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   output logic [SIZE-1:0]       o_imem_data,
   output logic                  o_cpu_rst,
   output logic                  o_run,
   output logic                  o_step,
   output logic                  o_dump_req,
   output logic [2:0]            o_dump_sel,
   input  logic                  i_dump_done,
   output logic                  o_step_mode,
   output logic [1:0]            o_err
);

   localparam int CNT_W = $clog2(MAX_INSTRUCTION + 1);

   state_t           state, state_nxt;
   logic             cmd_valid;
   logic             is_dump_cmd;
   logic             eol;
   logic             load_byte;
   logic             load_start;
   logic             word_ready;
   logic             asm_empty;
   logic             full;
   logic             started;
   logic [CNT_W-1:0] word_cnt;

   word_assembler #(.SIZE(SIZE)) u_word_assembler (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .clr        (load_start),
      .byte_valid (load_byte),
      .byte_data  (i_rx_data),
      .word       (o_imem_data),
      .word_ready (word_ready),
      .empty      (asm_empty)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && i_rx_data == CMD_LOAD) state_nxt = ST_LOAD;
            else if (cmd_valid && is_dump_cmd)      state_nxt = ST_DUMP;
         end
         ST_LOAD: if (eol)         state_nxt = ST_IDLE;
         ST_DUMP: if (i_dump_done) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      is_dump_cmd = (i_rx_data >= CMD_DUMP_REGS) && (i_rx_data <= CMD_DUMP_MEMWB);
      cmd_valid   = i_rx_valid && (state == ST_IDLE);
      load_start  = cmd_valid && (i_rx_data == CMD_LOAD);
      // 0x0C only terminates a load on a word boundary; mid-word it is data.
      eol         = i_rx_valid && (state == ST_LOAD) && asm_empty && (i_rx_data == CMD_EOL);
      load_byte   = i_rx_valid && (state == ST_LOAD) && !eol;
      full        = (word_cnt == CNT_W'(MAX_INSTRUCTION));
      o_imem_we   = word_ready && !full;
      o_dump_req  = (state == ST_DUMP);
      o_run       = started && !o_step_mode;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         started     <= 1'b0;
         o_step_mode <= 1'b0;
         o_cpu_rst   <= 1'b0;
         o_step      <= 1'b0;
         o_dump_sel  <= DSEL_REGS;
         o_imem_addr <= '0;
         word_cnt    <= '0;
         o_err       <= 2'b00;
      end else begin
         o_cpu_rst <= 1'b0;
         o_step    <= 1'b0;
         if (cmd_valid) begin
            case (i_rx_data)
               CMD_LOAD: begin
                  started     <= 1'b0;
                  word_cnt    <= '0;
                  o_imem_addr <= '0;
               end
               CMD_CONT:      o_step_mode <= 1'b0;
               CMD_STEP_MODE: o_step_mode <= 1'b1;
               CMD_STEP:      o_step      <= started && o_step_mode;
               CMD_START: begin
                  o_cpu_rst <= 1'b1;
                  started   <= 1'b1;
               end
               default: if (is_dump_cmd) o_dump_sel <= dump_sel_of(i_rx_data);
            endcase
         end
         if (o_imem_we) begin
            o_imem_addr <= o_imem_addr + ADDR_WIDTH'(4);
            word_cnt    <= word_cnt + 1'b1;
         end
         if (word_ready && full)               o_err[0] <= 1'b1;
         if (i_rx_valid && state == ST_DUMP)   o_err[1] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Bench for debug_cmd_decoder: directed scenarios plus random byte traffic,
// all compared every cycle against a behavioural model of the command rules.
module tb_debug_cmd_decoder;

   localparam int MAXI = 64;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_valid = 1'b0;
   logic        i_dump_done = 1'b0;
   logic        o_imem_we;
   logic [31:0] o_imem_addr;
   logic [31:0] o_imem_data;
   logic        o_cpu_rst, o_run, o_step, o_dump_req, o_step_mode;
   logic [2:0]  o_dump_sel;
   logic [1:0]  o_err;

   debug_cmd_decoder dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_rx_data   (i_rx_data),
      .i_rx_valid  (i_rx_valid),
      .o_imem_we   (o_imem_we),
      .o_imem_addr (o_imem_addr),
      .o_imem_data (o_imem_data),
      .o_cpu_rst   (o_cpu_rst),
      .o_run       (o_run),
      .o_step      (o_step),
      .o_dump_req  (o_dump_req),
      .o_dump_sel  (o_dump_sel),
      .i_dump_done (i_dump_done),
      .o_step_mode (o_step_mode),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Behavioural model: mode 0=idle 1=load 2=dump
   int          m_mode;
   bit          m_started, m_step_mode;
   logic [7:0]  m_q[$];
   int          m_nwords;
   int unsigned m_addr;
   bit [1:0]    m_err;
   bit [2:0]    m_sel;
   bit          pend_write, pend_err;
   bit          e_we, e_rst, e_step;
   logic [31:0] e_data;

   int          wr_seen, step_seen, rst_seen;
   int unsigned last_wr_addr;

   function automatic void model_reset();
      m_mode = 0; m_started = 0; m_step_mode = 0; m_q.delete();
      m_nwords = 0; m_addr = 0; m_err = 0; m_sel = 0;
      pend_write = 0; pend_err = 0; e_we = 0; e_rst = 0; e_step = 0; e_data = 0;
   endfunction

   function automatic void model_step(bit v, logic [7:0] d, bit done);
      e_we = 0; e_rst = 0; e_step = 0;
      if (pend_write) begin m_addr += 4; m_nwords++; pend_write = 0; end
      if (pend_err) begin m_err[0] = 1; pend_err = 0; end
      if (m_mode == 2) begin
         if (v) m_err[1] = 1;
         if (done) m_mode = 0;
      end else if (v && m_mode == 0) begin
         if (d == 8'h02) begin
            m_mode = 1; m_q.delete(); m_nwords = 0; m_addr = 0; m_started = 0;
         end else if (d >= 8'h03 && d <= 8'h07) begin
            m_mode = 2; m_sel = 3'(d - 8'h03);
         end else if (d == 8'h08) m_step_mode = 0;
         else if (d == 8'h09) m_step_mode = 1;
         else if (d == 8'h0A) e_step = m_started && m_step_mode;
         else if (d == 8'h0D) begin e_rst = 1; m_started = 1; end
      end else if (v && m_mode == 1) begin
         if (d == 8'h0C && m_q.size() == 0) m_mode = 0;
         else begin
            m_q.push_back(d);
            if (m_q.size() == 4) begin
               if (m_nwords < MAXI) begin
                  e_we = 1; e_data = {m_q[3], m_q[2], m_q[1], m_q[0]}; pend_write = 1;
               end else pend_err = 1;
               m_q.delete();
            end
         end
      end
   endfunction

   task automatic check_outputs();
      chk("we", o_imem_we, e_we);
      chk("addr", o_imem_addr, m_addr);
      if (e_we) chk("data", o_imem_data, e_data);
      chk("cpu_rst", o_cpu_rst, e_rst);
      chk("step", o_step, e_step);
      chk("run", o_run, m_started && !m_step_mode);
      chk("step_mode", o_step_mode, m_step_mode);
      chk("dump_req", o_dump_req, m_mode == 2);
      chk("dump_sel", o_dump_sel, m_sel);
      chk("err", o_err, m_err);
   endtask

   task automatic tick(input bit v, input logic [7:0] d, input bit done);
      i_rx_valid = v; i_rx_data = d; i_dump_done = done;
      model_step(v, d, done);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rx_valid = 0; i_dump_done = 0;
      check_outputs();
      if (o_imem_we) begin wr_seen++; last_wr_addr = o_imem_addr; end
      if (o_step) step_seen++;
      if (o_cpu_rst) rst_seen++;
   endtask

   task automatic send(input logic [7:0] d);
      tick(1, d, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 8'h00, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_we"}, o_imem_we, 0);
      chk({tag, "_addr"}, o_imem_addr, 0);
      chk({tag, "_data"}, o_imem_data, 0);
      chk({tag, "_ctl"}, {o_cpu_rst, o_run, o_step, o_dump_req, o_step_mode}, 0);
      chk({tag, "_sel"}, o_dump_sel, 0);
      chk({tag, "_err"}, o_err, 0);
   endtask

   int w0, s0, r0;
   logic [7:0] b;

   initial begin
      model_reset();
      wr_seen = 0; step_seen = 0; rst_seen = 0; last_wr_addr = 0;
      repeat (3) @(negedge i_clk);
      check_all_zero("reset");
      i_rst_n = 1'b1;
      idle(2);

      // single word load
      w0 = wr_seen;
      send(8'h02);
      send(8'h03); send(8'h00); send(8'h01); send(8'h3C);
      chk("w1_we", o_imem_we, 1);
      chk("w1_addr", o_imem_addr, 0);
      chk("w1_data", o_imem_data, 32'h3C010003);
      send(8'h0C);
      idle(2);
      chk("w1_count", wr_seen - w0, 1);
      send(8'h03);
      chk("w1_idle", o_dump_req, 1);
      tick(0, 8'h00, 1);
      idle(1);

      // overflow load: 65 words
      w0 = wr_seen;
      send(8'h02);
      for (int w = 0; w < MAXI + 1; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'($urandom_range(0, 255));
            if (k == 0 && b == 8'h0C) b = 8'h0D;
            send(b);
            if ($urandom_range(0, 3) == 0) idle(1);
         end
      end
      send(8'h0C);
      idle(2);
      chk("ovf_count", wr_seen - w0, MAXI);
      chk("ovf_last_addr", last_wr_addr, 252);
      chk("ovf_err0", o_err[0], 1);

      // step mode
      s0 = step_seen; r0 = rst_seen;
      send(8'h09); send(8'h0D);
      for (int i = 0; i < 3; i++) begin send(8'h0A); idle(2); end
      chk("stp_rst", rst_seen - r0, 1);
      chk("stp_run", o_run, 0);
      chk("stp_steps", step_seen - s0, 3);

      // byte dropped during dump
      s0 = step_seen;
      send(8'h05);
      send(8'h0A);
      chk("dmp_sel", o_dump_sel, 2);
      chk("dmp_req", o_dump_req, 1);
      chk("dmp_err1", o_err[1], 1);
      idle(2);
      tick(0, 8'h00, 1);
      chk("dmp_done", o_dump_req, 0);
      chk("dmp_nostep", step_seen - s0, 0);

      // continuous then step
      send(8'h08); send(8'h0D);
      chk("run_on", o_run, 1);
      send(8'h09);
      chk("run_off", o_run, 0);
      s0 = step_seen;
      send(8'h0A);
      idle(2);
      chk("run_step", step_seen - s0, 1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bit v, dn;
         v = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 0) b = 8'($urandom_range(1, 14));
         else b = 8'($urandom_range(0, 255));
         dn = (m_mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 19) == 0);
         tick(v, b, dn);
      end
      tick(0, 8'h00, 1);
      idle(2);

      // reset in the middle of a load
      send(8'h02);
      send(8'hAA); send(8'h55);
      #2 i_rst_n = 1'b0;
      #1 check_all_zero("midrst");
      model_reset();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      idle(1);
      w0 = wr_seen;
      send(8'h02);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("fresh_we", o_imem_we, 1);
      chk("fresh_addr", o_imem_addr, 0);
      chk("fresh_data", o_imem_data, 32'h44332211);
      send(8'h0C);
      idle(2);
      chk("fresh_count", wr_seen - w0, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
